// File: rtl/seq_unsigned_divider.sv
// Radix-2 restoring divider: DW-bit unsigned dividend by VW-bit unsigned divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
module seq_unsigned_divider #(
   parameter int DW = 16,
   parameter int VW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   // The partial remainder is always below the divisor, so its extra top bit
   // is never set; only the trial value needs the full VW+1 bits.
   logic [VW-1:0] r_q, r_d;
   logic [DW-1:0] q_q, q_d;
   logic [VW-1:0] divisor_q, divisor_d;
   logic [DW-1:0] quotient_q, quotient_d;
   logic [VW-1:0] remainder_q, remainder_d;
   logic          dbz_q, dbz_d;

   logic [VW:0]   trial;
   logic          fits;
   logic [VW-1:0] diff;
   logic [VW-1:0] r_step;
   logic [DW-1:0] q_step;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      trial  = {r_q, q_q[DW-1]};
      fits   = (trial >= {1'b0, divisor_q});
      diff   = trial[VW-1:0] - divisor_q;
      r_step = fits ? diff : trial[VW-1:0];
      q_step = {q_q[DW-2:0], fits};
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      r_d         = r_q;
      q_d         = q_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               divisor_d = divisor;
               if (divisor != '0) begin
                  r_d     = '0;
                  q_d     = dividend;
                  count_d = CW'(DW - 1);
                  state_d = S_RUN;
               end else begin
                  quotient_d  = '1;
                  remainder_d = '0;
                  dbz_d       = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_RUN: begin
            r_d = r_step;
            q_d = q_step;
            if (count_q == '0) begin
               quotient_d  = q_step;
               remainder_d = r_step;
               dbz_d       = 1'b0;
               state_d     = S_DONE;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         r_q         <= '0;
         q_q         <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         r_q         <= r_d;
         q_q         <= q_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Directed and random checks of seq_unsigned_divider against plain '/' and '%'
// arithmetic, including handshake timing, backpressure and reset aborts.
module tb_seq_unsigned_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_unsigned_divider #(.DW(16), .VW(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Latency is counted in clock edges after the accepting edge; a zero
   // divisor presents its result straight after the accepting edge.
   task automatic run_div(input logic [15:0] a, input logic [7:0] b, input int stall);
      logic [15:0] exp_q;
      logic [7:0]  exp_r;
      logic        exp_dbz;
      int          exp_lat;
      int          lat;
      if (b == 8'd0) begin
         exp_q = 16'hFFFF; exp_r = 8'd0; exp_dbz = 1'b1; exp_lat = 0;
      end else begin
         exp_q = a / 16'(b); exp_r = 8'(a % 16'(b)); exp_dbz = 1'b0; exp_lat = 16;
      end
      check("in_ready_idle", 32'(in_ready), 32'd1);
      dividend  = a;
      divisor   = b;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      // Operands may wander after acceptance and extra requests must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("out_valid", 32'(out_valid), 32'd1);
      check("in_ready_busy", 32'(in_ready), 32'd0);
      check("quotient", 32'(quotient), 32'(exp_q));
      check("remainder", 32'(remainder), 32'(exp_r));
      check("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
      if (b != 8'd0) begin
         check("invariant_sum", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
         check("invariant_rem_lt", 32'(remainder < b), 32'd1);
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_ready", 32'(in_ready), 32'd0);
         check("stall_quotient", 32'(quotient), 32'(exp_q));
         check("stall_remainder", 32'(remainder), 32'(exp_r));
         check("stall_dbz", 32'(div_by_zero), 32'(exp_dbz));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("post_valid", 32'(out_valid), 32'd0);
      check("post_ready", 32'(in_ready), 32'd1);
      check("post_quotient_hold", 32'(quotient), 32'(exp_q));
      $display("div %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d stall=%0d",
               a, b, quotient, remainder, div_by_zero, lat, stall);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_quotient", 32'(quotient), 32'd0);
      check("reset_remainder", 32'(remainder), 32'd0);
      check("reset_dbz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_div(16'd1000, 8'd7, 0);
      run_div(16'd30000, 8'd150, 0);
      run_div(16'd65535, 8'd255, 0);
      run_div(16'd65535, 8'd1, 0);
      run_div(16'd5, 8'd0, 0);
      run_div(16'd9, 8'd3, 0);
      run_div(16'd1000, 8'd7, 20);
      run_div(16'd3, 8'd200, 1);
      run_div(16'd0, 8'd9, 0);

      // Abort mid-RUN: the in-flight result must never appear.
      dividend = 16'd50000;
      divisor  = 8'd123;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_quotient", 32'(quotient), 32'd0);
      check("abort_remainder", 32'(remainder), 32'd0);
      check("abort_dbz", 32'(div_by_zero), 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("abort_quiet", 32'(out_valid), 32'd0);
      end
      run_div(16'd50000, 8'd123, 0);

      // Reset wins over a simultaneous request.
      dividend = 16'd5;
      divisor  = 8'd0;
      in_valid = 1'b1;
      rst_n    = 1'b0;
      @(posedge clk); #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      rst_n    = 1'b1;
      check("rst_prio_out_valid", 32'(out_valid), 32'd0);
      check("rst_prio_in_ready", 32'(in_ready), 32'd1);
      check("rst_prio_dbz", 32'(div_by_zero), 32'd0);
      @(posedge clk); #1;
      check("rst_prio_still_idle", 32'(in_ready), 32'd1);

      for (int n = 0; n < 2000; n++) begin
         logic [15:0] ra;
         logic [7:0]  rb;
         ra = 16'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         run_div(ra, rb, int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
